// File: rtl/load_queue_pkg.sv
// Shared widths, entry-state bit positions and a clog2 helper for the load queue.
package lq_pkg;

  function automatic int lq_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  localparam int LQ_DEPTH      = 16;
  localparam int LQ_WIDTH_ADDR = 32;
  localparam int LQ_WIDTH_REG  = 7;
  localparam int LQ_WIDTH_TAG  = 5;
  localparam int LQ_WIDTH_IDX  = lq_clog2(LQ_DEPTH);

  // Per-entry state vector: valid, address-valid, issued, done.
  localparam int ST_VAL = 0;
  localparam int ST_A   = 1;
  localparam int ST_I   = 2;
  localparam int ST_D   = 3;
  localparam int ST_W   = 4;

  typedef logic [ST_W-1:0] lq_state_t;

endpackage

// File: rtl/load_queue_if.sv
// Bus bundle between the load queue and dispatch / AGU / data-cache port.
interface lq_if
  import lq_pkg::*;
#(
  parameter int WIDTH_ADDR = LQ_WIDTH_ADDR,
  parameter int WIDTH_REG  = LQ_WIDTH_REG,
  parameter int WIDTH_TAG  = LQ_WIDTH_TAG,
  parameter int WIDTH_IDX  = LQ_WIDTH_IDX
) ();

  // Handshakes: a transfer happens on a clock edge where valid and ready are
  // both high; ready never depends combinationally on the same-cycle valid.
  logic                  i_alloc_valid;
  logic [WIDTH_REG-1:0]  i_alloc_rd;
  logic [WIDTH_TAG-1:0]  i_alloc_tag;
  logic                  o_alloc_ready;
  logic [WIDTH_IDX-1:0]  o_alloc_idx;

  logic                  i_addr_valid;
  logic [WIDTH_IDX-1:0]  i_addr_idx;
  logic [WIDTH_ADDR-1:0] i_addr;

  logic                  o_iss_valid;
  logic [WIDTH_IDX-1:0]  o_iss_idx;
  logic [WIDTH_ADDR-1:0] o_iss_addr;
  logic [WIDTH_REG-1:0]  o_iss_rd;
  logic [WIDTH_TAG-1:0]  o_iss_tag;
  logic                  i_iss_ready;

  logic                  i_replay_valid;
  logic [WIDTH_IDX-1:0]  i_replay_idx;
  logic                  i_done_valid;
  logic [WIDTH_IDX-1:0]  i_done_idx;

  logic                  o_head_done;
  logic [WIDTH_TAG-1:0]  o_head_tag;
  logic                  i_pop;

  logic                  i_kill_valid;
  logic [WIDTH_IDX-1:0]  i_kill_idx;

  logic                  o_empty;
  logic                  o_full;
  logic [WIDTH_IDX:0]    o_count;

  modport slave (
    input  i_alloc_valid, i_alloc_rd, i_alloc_tag,
    output o_alloc_ready, o_alloc_idx,
    input  i_addr_valid, i_addr_idx, i_addr,
    output o_iss_valid, o_iss_idx, o_iss_addr, o_iss_rd, o_iss_tag,
    input  i_iss_ready,
    input  i_replay_valid, i_replay_idx, i_done_valid, i_done_idx,
    output o_head_done, o_head_tag,
    input  i_pop, i_kill_valid, i_kill_idx,
    output o_empty, o_full, o_count
  );

  modport master (
    output i_alloc_valid, i_alloc_rd, i_alloc_tag,
    input  o_alloc_ready, o_alloc_idx,
    output i_addr_valid, i_addr_idx, i_addr,
    input  o_iss_valid, o_iss_idx, o_iss_addr, o_iss_rd, o_iss_tag,
    output i_iss_ready,
    output i_replay_valid, i_replay_idx, i_done_valid, i_done_idx,
    input  o_head_done, o_head_tag,
    output i_pop, i_kill_valid, i_kill_idx,
    input  o_empty, o_full, o_count
  );

endinterface

// File: rtl/load_queue_age_select.sv
// Oldest-first picker: scans the ready vector in age order starting at head.
module lq_age_select #(
  parameter int DEPTH     = 16,
  parameter int WIDTH_IDX = 4
) (
  input  logic [DEPTH-1:0]     ready_i,
  input  logic [WIDTH_IDX-1:0] head_idx_i,
  output logic                 valid_o,
  output logic [WIDTH_IDX-1:0] idx_o
);

  logic [WIDTH_IDX-1:0] slot;

  // Walk from youngest to oldest so the last hit (oldest) wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    slot    = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      slot = head_idx_i + WIDTH_IDX'(k);
      if (ready_i[slot]) begin
        valid_o = 1'b1;
        idx_o   = slot;
      end
    end
  end

endmodule

// File: rtl/load_queue.sv
// Circular load queue: in-order allocate, out-of-order issue, partial flush on kill.
module load_queue
  import lq_pkg::*;
#(
  parameter int DEPTH      = LQ_DEPTH,
  parameter int WIDTH_ADDR = LQ_WIDTH_ADDR,
  parameter int WIDTH_REG  = LQ_WIDTH_REG,
  parameter int WIDTH_TAG  = LQ_WIDTH_TAG,
  parameter int WIDTH_IDX  = $clog2(DEPTH)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  lq_if.slave  bus
);

  localparam int W = WIDTH_IDX;
  localparam logic [W:0] DEPTH_P = (W+1)'(DEPTH);

  logic [W:0]            head_q, head_d, tail_q, tail_d;
  lq_state_t             st_q   [DEPTH];
  lq_state_t             st_d   [DEPTH];
  logic [WIDTH_ADDR-1:0] addr_q [DEPTH];
  logic [WIDTH_ADDR-1:0] addr_d [DEPTH];
  logic [WIDTH_REG-1:0]  rd_q   [DEPTH];
  logic [WIDTH_REG-1:0]  rd_d   [DEPTH];
  logic [WIDTH_TAG-1:0]  tag_q  [DEPTH];
  logic [WIDTH_TAG-1:0]  tag_d  [DEPTH];

  logic [W-1:0]     head_idx, tail_idx, kill_cnt, iss_idx;
  logic [W:0]       count;
  logic             full, head_done, iss_valid;
  logic [DEPTH-1:0] ready_vec;
  logic             alloc_fire, iss_fire, pop_fire, pop_eff, kill_fire;

  assign head_idx  = head_q[W-1:0];
  assign tail_idx  = tail_q[W-1:0];
  assign count     = tail_q - head_q;
  assign full      = (count == DEPTH_P);
  assign head_done = st_q[head_idx][ST_VAL] & st_q[head_idx][ST_D];

  always_comb begin
    ready_vec = '0;
    for (int j = 0; j < DEPTH; j++) begin
      ready_vec[j] = st_q[j][ST_VAL] & st_q[j][ST_A] & ~st_q[j][ST_I] & ~st_q[j][ST_D];
    end
  end

  lq_age_select #(
    .DEPTH     (DEPTH),
    .WIDTH_IDX (W)
  ) u_age_select (
    .ready_i    (ready_vec),
    .head_idx_i (head_idx),
    .valid_o    (iss_valid),
    .idx_o      (iss_idx)
  );

  // Kill only counts when it names a live slot; killing at head empties the queue
  // and then swallows any same-cycle pop.
  assign kill_fire  = bus.i_kill_valid & st_q[bus.i_kill_idx][ST_VAL];
  assign kill_cnt   = bus.i_kill_idx - head_idx;
  assign alloc_fire = bus.i_alloc_valid & ~full & ~kill_fire;
  assign iss_fire   = iss_valid & bus.i_iss_ready;
  assign pop_fire   = bus.i_pop & head_done;
  assign pop_eff    = pop_fire & ~(kill_fire & (kill_cnt == '0));

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (pop_eff) head_d = head_q + (W+1)'(1);
    if (kill_fire) begin
      tail_d = head_q + {1'b0, kill_cnt};
    end else if (alloc_fire) begin
      tail_d = tail_q + (W+1)'(1);
    end
  end

  // Order inside a live slot: addr, issue, replay, done; replay beats issue,
  // done and replay coexist. Pop and kill clear val last so they win.
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      st_d[j]   = st_q[j];
      addr_d[j] = addr_q[j];
      rd_d[j]   = rd_q[j];
      tag_d[j]  = tag_q[j];
      if (st_q[j][ST_VAL]) begin
        if (bus.i_addr_valid && bus.i_addr_idx == W'(j)) begin
          st_d[j][ST_A] = 1'b1;
          addr_d[j]     = bus.i_addr;
        end
        if (iss_fire && iss_idx == W'(j))                        st_d[j][ST_I] = 1'b1;
        if (bus.i_replay_valid && bus.i_replay_idx == W'(j))     st_d[j][ST_I] = 1'b0;
        if (bus.i_done_valid && bus.i_done_idx == W'(j))         st_d[j][ST_D] = 1'b1;
      end
      if (alloc_fire && tail_idx == W'(j)) begin
        st_d[j]          = '0;
        st_d[j][ST_VAL]  = 1'b1;
        rd_d[j]          = bus.i_alloc_rd;
        tag_d[j]         = bus.i_alloc_tag;
      end
      if (pop_eff && head_idx == W'(j)) st_d[j][ST_VAL] = 1'b0;
      if (kill_fire && ((W'(j) - head_idx) >= kill_cnt)) st_d[j][ST_VAL] = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        st_q[j]   <= '0;
        addr_q[j] <= '0;
        rd_q[j]   <= '0;
        tag_q[j]  <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      for (int j = 0; j < DEPTH; j++) begin
        st_q[j]   <= st_d[j];
        addr_q[j] <= addr_d[j];
        rd_q[j]   <= rd_d[j];
        tag_q[j]  <= tag_d[j];
      end
    end
  end

  assign bus.o_alloc_ready = ~full;
  assign bus.o_alloc_idx   = tail_idx;
  assign bus.o_iss_valid   = iss_valid;
  assign bus.o_iss_idx     = iss_idx;
  assign bus.o_iss_addr    = addr_q[iss_idx];
  assign bus.o_iss_rd      = rd_q[iss_idx];
  assign bus.o_iss_tag     = tag_q[iss_idx];
  assign bus.o_head_done   = head_done;
  assign bus.o_head_tag    = tag_q[head_idx];
  assign bus.o_empty       = (count == '0);
  assign bus.o_full        = full;
  assign bus.o_count       = count;

endmodule

// File: tb/tb_load_queue.sv
// Bench for load_queue: directed scenarios plus random traffic against a queue-based model.
module tb_load_queue;
  import lq_pkg::*;

  localparam int D  = 16;
  localparam int WA = 32;
  localparam int WR = 7;
  localparam int WT = 5;
  localparam int WI = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lq_if #(.WIDTH_ADDR(WA), .WIDTH_REG(WR), .WIDTH_TAG(WT), .WIDTH_IDX(WI)) bus ();

  load_queue #(
    .DEPTH(D), .WIDTH_ADDR(WA), .WIDTH_REG(WR), .WIDTH_TAG(WT), .WIDTH_IDX(WI)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic          alloc_v;
    logic [WR-1:0] rd;
    logic [WT-1:0] tag;
    logic          addr_v;
    logic [WI-1:0] addr_idx;
    logic [WA-1:0] addr;
    logic          iss_rdy;
    logic          rep_v;
    logic [WI-1:0] rep_idx;
    logic          done_v;
    logic [WI-1:0] done_idx;
    logic          pop;
    logic          kill_v;
    logic [WI-1:0] kill_idx;
  } stim_t;

  typedef struct {
    int            slot;
    logic [WR-1:0] rd;
    logic [WT-1:0] tag;
    bit            a, i, d;
    logic [WA-1:0] addr;
  } ent_t;

  // Reference: live loads in age order; mq[0] is the head entry.
  ent_t mq[$];
  int   m_head = 0;
  int   n_vec  = 0;
  int   n_err  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic int cand_pos();
    for (int k = 0; k < mq.size(); k++)
      if (mq[k].a && !mq[k].i && !mq[k].d) return k;
    return -1;
  endfunction

  task automatic apply(input stim_t s);
    bus.i_alloc_valid  = s.alloc_v;
    bus.i_alloc_rd     = s.rd;
    bus.i_alloc_tag    = s.tag;
    bus.i_addr_valid   = s.addr_v;
    bus.i_addr_idx     = s.addr_idx;
    bus.i_addr         = s.addr;
    bus.i_iss_ready    = s.iss_rdy;
    bus.i_replay_valid = s.rep_v;
    bus.i_replay_idx   = s.rep_idx;
    bus.i_done_valid   = s.done_v;
    bus.i_done_idx     = s.done_idx;
    bus.i_pop          = s.pop;
    bus.i_kill_valid   = s.kill_v;
    bus.i_kill_idx     = s.kill_idx;
  endtask

  task automatic compare_model();
    int c, sz;
    c  = cand_pos();
    sz = mq.size();
    check("count", 64'(bus.o_count), 64'(sz));
    check("empty", 64'(bus.o_empty), 64'(sz == 0));
    check("full", 64'(bus.o_full), 64'(sz == D));
    check("alloc_ready", 64'(bus.o_alloc_ready), 64'(sz < D));
    check("alloc_idx", 64'(bus.o_alloc_idx), 64'((m_head + sz) % D));
    check("iss_valid", 64'(bus.o_iss_valid), 64'(c >= 0));
    if (c >= 0) begin
      check("iss_idx", 64'(bus.o_iss_idx), 64'(mq[c].slot));
      check("iss_addr", 64'(bus.o_iss_addr), 64'(mq[c].addr));
      check("iss_rd", 64'(bus.o_iss_rd), 64'(mq[c].rd));
      check("iss_tag", 64'(bus.o_iss_tag), 64'(mq[c].tag));
    end
    check("head_done", 64'(bus.o_head_done), 64'(sz > 0 && mq[0].d));
    if (sz > 0) check("head_tag", 64'(bus.o_head_tag), 64'(mq[0].tag));
  endtask

  task automatic model_step(input stim_t s);
    bit   hd;
    int   c, sz, aslot, kpos;
    ent_t e;
    sz    = mq.size();
    hd    = (sz > 0) && mq[0].d;
    c     = cand_pos();
    aslot = (m_head + sz) % D;
    for (int k = 0; k < sz; k++) begin
      if (s.addr_v && mq[k].slot == int'(s.addr_idx)) begin
        mq[k].a    = 1'b1;
        mq[k].addr = s.addr;
      end
      if (s.iss_rdy && k == c) mq[k].i = 1'b1;
      if (s.rep_v && mq[k].slot == int'(s.rep_idx)) mq[k].i = 1'b0;
      if (s.done_v && mq[k].slot == int'(s.done_idx)) mq[k].d = 1'b1;
    end
    kpos = -1;
    if (s.kill_v)
      for (int k = 0; k < sz; k++) if (mq[k].slot == int'(s.kill_idx)) kpos = k;
    if (kpos >= 0) begin
      while (mq.size() > kpos) void'(mq.pop_back());
      if (s.pop && hd && kpos > 0) begin
        void'(mq.pop_front());
        m_head = (m_head + 1) % D;
      end
    end else begin
      if (s.pop && hd) begin
        void'(mq.pop_front());
        m_head = (m_head + 1) % D;
      end
      if (s.alloc_v && sz < D) begin
        e.slot = aslot; e.rd = s.rd; e.tag = s.tag;
        e.a = 0; e.i = 0; e.d = 0; e.addr = '0;
        mq.push_back(e);
      end
    end
  endtask

  task automatic cycle(input stim_t s);
    @(negedge clk);
    apply(s);
    #1 compare_model();
    @(posedge clk);
    model_step(s);
    #1 apply(idle());
  endtask

  task automatic probe();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    apply(idle());
    rst_n = 1'b0;
    mq.delete();
    m_head = 0;
    #1 compare_model();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic alloc_n(input int n);
    stim_t s;
    for (int k = 0; k < n; k++) begin
      s = idle(); s.alloc_v = 1; s.tag = WT'(k + 1); s.rd = WR'(k + 10);
      cycle(s);
    end
  endtask

  function automatic logic [WI-1:0] pick_slot();
    if (mq.size() > 0) return WI'(mq[$urandom_range(0, mq.size() - 1)].slot);
    return WI'($urandom_range(0, D - 1));
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s          = idle();
    s.alloc_v  = ($urandom_range(0, 9) < 6);
    s.rd       = WR'($urandom);
    s.tag      = WT'($urandom);
    s.addr_v   = ($urandom_range(0, 9) < 5);
    s.addr_idx = pick_slot();
    s.addr     = $urandom;
    s.iss_rdy  = ($urandom_range(0, 9) < 7);
    s.rep_v    = ($urandom_range(0, 9) < 1);
    s.rep_idx  = pick_slot();
    s.done_v   = ($urandom_range(0, 9) < 3);
    s.done_idx = pick_slot();
    s.pop      = ($urandom_range(0, 9) < 5);
    s.kill_v   = ($urandom_range(0, 31) == 0);
    s.kill_idx = pick_slot();
    return s;
  endfunction

  initial begin
    stim_t s;
    int    order [3];
    order = '{2, 0, 1};
    apply(idle());

    // Oldest-first select regardless of address order
    do_reset();
    alloc_n(3);
    foreach (order[k]) begin
      s = idle(); s.addr_v = 1; s.addr_idx = WI'(order[k]); s.addr = 32'h1000 + 32'(order[k] * 4);
      cycle(s);
    end
    for (int e = 0; e < 3; e++) begin
      probe();
      check("order", 64'(bus.o_iss_idx), 64'(e));
      s = idle(); s.iss_rdy = 1;
      cycle(s);
    end

    // Full queue, dropped alloc, pop+alloc refused
    do_reset();
    alloc_n(16);
    probe();
    check("full_flag", 64'(bus.o_full), 64'd1);
    check("full_ready", 64'(bus.o_alloc_ready), 64'd0);
    check("full_count", 64'(bus.o_count), 64'd16);
    alloc_n(1);
    probe();
    check("alloc17", 64'(bus.o_count), 64'd16);
    s = idle(); s.done_v = 1; s.done_idx = 0; cycle(s);
    s = idle(); s.pop = 1; s.alloc_v = 1; cycle(s);
    probe();
    check("pop_alloc", 64'(bus.o_count), 64'd15);

    // Wrap-around
    do_reset();
    alloc_n(12);
    for (int k = 0; k < 12; k++) begin
      s = idle(); s.done_v = 1; s.done_idx = WI'(k); cycle(s);
    end
    for (int k = 0; k < 12; k++) begin
      s = idle(); s.pop = 1; cycle(s);
    end
    alloc_n(8);
    probe();
    check("wrap_count", 64'(bus.o_count), 64'd8);
    check("wrap_tail", 64'(bus.o_alloc_idx), 64'd4);
    s = idle(); s.addr_v = 1; s.addr_idx = 1;  s.addr = 32'hA1; cycle(s);
    s = idle(); s.addr_v = 1; s.addr_idx = 13; s.addr = 32'hAD; cycle(s);
    probe();
    check("wrap_oldest", 64'(bus.o_iss_idx), 64'd13);

    // Partial kill with a dropped alloc, then kill at head
    do_reset();
    alloc_n(6);
    s = idle(); s.kill_v = 1; s.kill_idx = 3; s.alloc_v = 1; cycle(s);
    probe();
    check("kill_count", 64'(bus.o_count), 64'd3);
    check("kill_tail", 64'(bus.o_alloc_idx), 64'd3);
    s = idle(); s.kill_v = 1; s.kill_idx = 0; cycle(s);
    probe();
    check("kill_head", 64'(bus.o_empty), 64'd1);

    // Replay and done+replay
    do_reset();
    alloc_n(1);
    s = idle(); s.addr_v = 1; s.addr_idx = 0; s.addr = 32'hBEEF; cycle(s);
    s = idle(); s.iss_rdy = 1; cycle(s);
    probe();
    check("issued", 64'(bus.o_iss_valid), 64'd0);
    s = idle(); s.rep_v = 1; s.rep_idx = 0; cycle(s);
    probe();
    check("replay_sel", 64'(bus.o_iss_valid), 64'd1);
    check("replay_idx", 64'(bus.o_iss_idx), 64'd0);
    s = idle(); s.iss_rdy = 1; cycle(s);
    s = idle(); s.done_v = 1; s.done_idx = 0; s.rep_v = 1; s.rep_idx = 0; cycle(s);
    probe();
    check("done_rep_sel", 64'(bus.o_iss_valid), 64'd0);
    check("done_rep_head", 64'(bus.o_head_done), 64'd1);

    // Async reset mid-cycle with live entries
    do_reset();
    alloc_n(5);
    @(negedge clk);
    #2 rst_n = 1'b0;
    mq.delete();
    m_head = 0;
    #1 compare_model();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic
    repeat (1500) cycle(rand_stim());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/load_queue.md
# load_queue

Parametrised successor to the AGU load-address queue. It is an in-order-allocated, out-of-order-issued circular load queue with configurable depth and field widths. Each entry tracks address-valid, issued, done and kill state, and the block selects the oldest ready load for issue. It sits between rename/dispatch, which allocates entries, the AGU, which writes addresses, and the data-cache port, which issues, replays and completes loads. It supports partial flush on branch mispredict.

## Interface
Parameters:
- DEPTH, 16, number of entries; power of two, ≥ 4
- WIDTH_ADDR, 32, load address width
- WIDTH_REG, 7, physical destination register width
- WIDTH_TAG, 5, ROB tag width
- WIDTH_IDX, $clog2(DEPTH), slot index width (derived)

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_alloc_valid  in  1  allocate request
- i_alloc_rd  in  WIDTH_REG  destination register
- i_alloc_tag  in  WIDTH_TAG  ROB tag
- o_alloc_ready  out  1  not full
- o_alloc_idx  out  WIDTH_IDX  slot granted (tail)
- i_addr_valid  in  1  AGU address write
- i_addr_idx  in  WIDTH_IDX  target slot
- i_addr  in  WIDTH_ADDR  address
- o_iss_valid  out  1  issue candidate present
- o_iss_idx / o_iss_addr / o_iss_rd / o_iss_tag  out  —  candidate fields
- i_iss_ready  in  1  cache accepts candidate
- i_replay_valid, i_replay_idx  in  1, WIDTH_IDX  nack: entry returns to not-issued
- i_done_valid, i_done_idx  in  1, WIDTH_IDX  load completed
- o_head_done  out  1  head entry valid and done
- o_head_tag  out  WIDTH_TAG  head ROB tag
- i_pop  in  1  retire head
- i_kill_valid, i_kill_idx  in  1, WIDTH_IDX  squash slot kill_idx and all younger
- o_empty, o_full  out  1  status
- o_count  out  WIDTH_IDX+1  occupancy

## Operation
- Pointers: head and tail are WIDTH_IDX+1 bits, with the MSB as the wrap bit.
  - count = tail − head.
  - empty when count == 0; full when count == DEPTH.
- Entry fields: val, A (address valid), I (issued), D (done), addr, rd, tag.
- Alloc: fires when i_alloc_valid & o_alloc_ready.
  - Slot[tail] gets val=1, A=I=D=0, rd, tag.
  - tail increments.
- Address write: sets A=1 and writes addr. Ignored if slot val=0.
- Issue select: the oldest entry in age order from head with val & A & ~I & ~D.
  - Implemented as a rotate-by-head priority encoder.
  - Fires when o_iss_valid & i_iss_ready, which sets I.
- Replay: clears I, leaving the entry selectable again. Done: sets D. Both are ignored on a slot with val=0.
- Pop: fires when i_pop & o_head_done. Clears val at head; head increments. i_pop without o_head_done is ignored.
- Kill: fires only when slot kill_idx has val=1; otherwise ignored.
  - new count = (kill_idx − head_idx) mod DEPTH.
  - tail = head + new count.
  - val is cleared on the killed slots.
  - kill_idx == head_idx empties the queue.
- Same-cycle priority:
  - Kill beats alloc; the alloc is dropped and the tail is not advanced.
  - Kill beats done, replay, address write and issue on killed slots.
  - Pop is applied together with kill. If the kill empties the queue, the pop is ignored.
  - Done and replay on the same slot: done wins (D=1, I cleared).
  - Issue fire and replay on the same slot: replay wins (I=0).
- o_alloc_ready depends only on registered count. A full queue with pop in the same cycle still refuses the alloc.

## Timing
- Reset (async) values:
  - head = tail = 0.
  - All val/A/I/D = 0; addr, rd, tag = 0.
  - o_empty=1, o_full=0, o_count=0, o_alloc_ready=1, o_alloc_idx=0.
  - o_iss_valid=0, o_head_done=0.
- Reset asserted mid-operation discards all entries immediately.
- All state updates occur at posedge i_clk.
- All outputs are combinational from registered state only; there are no input-to-output paths.
- An allocated entry is visible to address write on the next cycle.
- The earliest issue is the cycle after the address write, so alloc→issue is at least 2 cycles.
- Done → o_head_done is high on the next cycle if the entry is at head.
- Pop and kill take effect on o_count the next cycle.

## Structure
- Package lq_pkg holds the entry field widths, the entry-state bit positions (VAL, A, I, D) and a clog2 helper constant.
- One sub-module, lq_age_select, takes a DEPTH-bit ready vector plus head_idx and returns {valid, idx} for the oldest set bit.
- Pointers and entry arrays live in load_queue.

## Test plan
- Reset, then alloc 3 (tags 1,2,3), write addresses to slots 2,0,1 in that order → the first issue candidate is slot 0, then 1, then 2, regardless of address order.
- Fill 16 entries → o_full=1, o_alloc_ready=0, o_count=16. A 17th alloc is dropped. Pop + alloc in the same cycle → alloc still refused that cycle.
- Wrap-around: fill 12, complete and pop 12, alloc 8 → slots 12..15,0..3 are used; o_count=8; the oldest-first select is still correct across the wrap.
- Kill mid-queue: alloc 6 from head=0, kill_idx=3 together with an alloc → o_count=3, tail=3, alloc dropped. kill_idx=head → o_empty=1.
- Replay: issue slot 0, replay slot 0 → it is reselected next cycle. Done + replay on the same slot in the same cycle → D=1 and it is not reselected; o_head_done=1.
- Async reset asserted with 5 live entries → all outputs return to their reset values before the next clock edge.
